guess_input_conditioner: RTL and testbench

//  Sits between the board switches/buttons and the game FSM.
//  - Synchronises and debounces the 4 guess switches, the ready switch and the submit button.
//  - Detects ready edges.
//  - Captures a guess on each submit press and hands it to the FSM over a valid/ack handshake.
//  - Flags out-of-range guesses for the current game mode and overrun (a submit while a guess is still pending).

---
 rtl/guess_input_conditioner_pkg.sv | 34 +++
 rtl/guess_input_conditioner_if.sv | 31 +++
 rtl/guess_input_conditioner_debounce_bit.sv | 78 +++++++
 rtl/guess_input_conditioner.sv | 107 ++++++++++
 tb/tb_guess_input_conditioner.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/guess_input_conditioner_pkg.sv
// Shared game constants and helpers for the guess input path.
//   GAME_MODE_*    : game mode codes as driven on gameMode
//   DEC_MAX/OCT_MAX: largest legal guess in decimal / octal games
//   CLK_HZ         : system clock frequency
//   db_state_e     : per-bit debounce FSM states
//   guess_in_range : legality of a guess for a given mode
package game_pkg;

  localparam logic [1:0] GAME_MODE_DEC = 2'b01;
  localparam logic [1:0] GAME_MODE_HEX = 2'b10;
  localparam logic [1:0] GAME_MODE_OCT = 2'b11;

  localparam int DEC_MAX = 9;
  localparam int OCT_MAX = 7;
  localparam int CLK_HZ  = 100_000_000;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_SETTLING = 1'b1
  } db_state_e;

  // Mode 2'b00 is treated as decimal, same as GAME_MODE_DEC.
  function automatic logic guess_in_range(input logic [1:0] mode, input int unsigned guess);
    logic ok;
    case (mode)
      GAME_MODE_HEX: ok = 1'b1;
      GAME_MODE_OCT: ok = (guess <= OCT_MAX);
      GAME_MODE_DEC: ok = (guess <= DEC_MAX);
      default:       ok = (guess <= DEC_MAX);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/guess_input_conditioner_if.sv
// Bundle of board-side raw inputs, FSM-side handshake and conditioned outputs.
//   master : board/FSM side (drives raw inputs, gameMode, guessAck)
//   slave  : the conditioner itself
interface guess_input_conditioner_if #(
  parameter int GUESS_W = 4
);
  logic [GUESS_W-1:0] guessRaw;
  logic               readyRaw;
  logic               submitRaw;
  logic [1:0]         gameMode;
  logic               guessAck;

  logic [GUESS_W-1:0] userGuess;
  logic               ready;
  logic               readyRise;
  logic               readyFall;
  logic               guessValid;
  logic [GUESS_W-1:0] guessData;
  logic               rangeErr;
  logic               overrun;

  modport master (
    output guessRaw, readyRaw, submitRaw, gameMode, guessAck,
    input  userGuess, ready, readyRise, readyFall, guessValid, guessData, rangeErr, overrun
  );

  modport slave (
    input  guessRaw, readyRaw, submitRaw, gameMode, guessAck,
    output userGuess, ready, readyRise, readyFall, guessValid, guessData, rangeErr, overrun
  );
endinterface

// File: rtl/guess_input_conditioner_debounce_bit.sv
// Single-bit synchroniser + debouncer.
//   clock, resetn : system clock, async active-low reset
//   din           : raw asynchronous input
//   dout          : debounced level; follows din only after din has held
//                   a new level for DEBOUNCE_CYCLES synced cycles
// Latency din -> dout is 2 (sync) + DEBOUNCE_CYCLES cycles.
module debounce_bit
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic resetn,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  db_state_e       state_q, state_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    case (state_q)
      DB_STABLE: begin
        if (sync2_q != stable_q) begin
          state_d = DB_SETTLING;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      DB_SETTLING: begin
        if (sync2_q == stable_q) begin
          // input bounced back before settling: discard the attempt
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          // >= rather than == keeps the counter from ever wrapping
          stable_d = sync2_q;
          state_d  = DB_STABLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = DB_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      state_q  <= DB_STABLE;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/guess_input_conditioner.sv
// Conditions the board switches/buttons for the game FSM.
//   clock, resetn : system clock, async active-low reset
//   gif (slave)   : raw guess/ready/submit, gameMode, guessAck in;
//                   debounced levels, ready edge pulses, captured guess
//                   with valid/ack handshake, rangeErr pulse, sticky overrun out
module guess_input_conditioner
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int GUESS_W         = 4
) (
  input logic                     clock,
  input logic                     resetn,
  guess_input_conditioner_if.slave gif
);

  localparam int NB = GUESS_W + 2;

  // bit layout: [GUESS_W+1] submit, [GUESS_W] ready, [GUESS_W-1:0] guess
  logic [NB-1:0] raw_bits, db_bits;

  assign raw_bits = {gif.submitRaw, gif.readyRaw, gif.guessRaw};

  for (genvar i = 0; i < NB; i++) begin : g_db
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock  (clock),
      .resetn (resetn),
      .din    (raw_bits[i]),
      .dout   (db_bits[i])
    );
  end

  logic [GUESS_W-1:0] guess_lvl;
  logic               ready_lvl, submit_lvl;

  assign guess_lvl  = db_bits[GUESS_W-1:0];
  assign ready_lvl  = db_bits[GUESS_W];
  assign submit_lvl = db_bits[GUESS_W+1];

  logic               ready_prev_q, submit_prev_q;
  logic               valid_q, valid_d;
  logic [GUESS_W-1:0] data_q, data_d;
  logic               rerr_q, rerr_d;
  logic               ovr_q, ovr_d;

  // Edge pulses compare two flops, so they are glitch-free and one cycle wide.
  logic ready_rise, ready_fall, submit_press, in_range;

  assign ready_rise   = ready_lvl & ~ready_prev_q;
  assign ready_fall   = ~ready_lvl & ready_prev_q;
  assign submit_press = submit_lvl & ~submit_prev_q;
  assign in_range     = guess_in_range(gif.gameMode, 32'(guess_lvl));

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    rerr_d  = 1'b0;
    ovr_d   = ovr_q;

    if (ready_rise) ovr_d = 1'b0;

    if (ready_fall) begin
      // game abandoned: drop any pending guess, ignore a coincident press
      valid_d = 1'b0;
    end else if (submit_press) begin
      if (!in_range) begin
        rerr_d = 1'b1;
      end else if (!valid_q || gif.guessAck) begin
        // ack in the same cycle frees the slot for back-to-back transfer
        data_d  = guess_lvl;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (gif.guessAck && valid_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ready_prev_q  <= 1'b0;
      submit_prev_q <= 1'b0;
      valid_q       <= 1'b0;
      data_q        <= '0;
      rerr_q        <= 1'b0;
      ovr_q         <= 1'b0;
    end else begin
      ready_prev_q  <= ready_lvl;
      submit_prev_q <= submit_lvl;
      valid_q       <= valid_d;
      data_q        <= data_d;
      rerr_q        <= rerr_d;
      ovr_q         <= ovr_d;
    end
  end

  assign gif.userGuess  = guess_lvl;
  assign gif.ready      = ready_lvl;
  assign gif.readyRise  = ready_rise;
  assign gif.readyFall  = ready_fall;
  assign gif.guessValid = valid_q;
  assign gif.guessData  = data_q;
  assign gif.rangeErr   = rerr_q;
  assign gif.overrun    = ovr_q;

endmodule

// File: tb/tb_guess_input_conditioner.sv
module tb_guess_input_conditioner;

  logic clock = 1'b0;
  logic resetn;

  guess_input_conditioner_if #(.GUESS_W(4)) gif ();

  guess_input_conditioner #(.DEBOUNCE_CYCLES(4), .GUESS_W(4)) dut (
    .clock  (clock),
    .resetn (resetn),
    .gif    (gif)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int valid_rises = 0;
  logic vprev = 1'b0;

  always @(negedge clock) begin
    vprev <= gif.guessValid;
    if (gif.guessValid && !vprev) valid_rises <= valid_rises + 1;
  end

  typedef struct {
    logic [1:0] mode;
    logic [3:0] guess;
    logic       accept;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic ack_pulse();
    gif.guessAck = 1'b1;
    tick(1);
    gif.guessAck = 1'b0;
  endtask

  initial begin
    int r0;
    vecs[0] = '{2'b10, 4'hC, 1'b1};
    vecs[1] = '{2'b11, 4'h8, 1'b0};
    vecs[2] = '{2'b11, 4'h7, 1'b1};
    vecs[3] = '{2'b01, 4'h9, 1'b1};
    vecs[4] = '{2'b01, 4'hA, 1'b0};
    vecs[5] = '{2'b00, 4'h9, 1'b1};
    vecs[6] = '{2'b00, 4'hA, 1'b0};
    vecs[7] = '{2'b10, 4'hF, 1'b1};

    resetn        = 1'b0;
    gif.guessRaw  = '0;
    gif.readyRaw  = 1'b0;
    gif.submitRaw = 1'b0;
    gif.gameMode  = 2'b10;
    gif.guessAck  = 1'b0;
    tick(2);
    chk("rst_valid",   32'(gif.guessValid), 0);
    chk("rst_data",    32'(gif.guessData), 0);
    chk("rst_overrun", 32'(gif.overrun), 0);
    chk("rst_ready",   32'(gif.ready), 0);
    chk("rst_rangeErr",32'(gif.rangeErr), 0);
    resetn = 1'b1;
    tick(8);

    // bounce: toggles every 2 cycles never settle; final hold captures once
    gif.guessRaw = 4'h3;
    tick(8);
    chk("bounce_userGuess", 32'(gif.userGuess), 3);
    r0 = valid_rises;
    for (int k = 0; k < 10; k++) begin
      gif.submitRaw = ~gif.submitRaw;
      tick(2);
    end
    chk("bounce_no_capture", 32'(gif.guessValid), 0);
    gif.submitRaw = 1'b1;
    tick(6);
    chk("bounce_valid_early", 32'(gif.guessValid), 0);
    tick(1);
    chk("bounce_valid_at7", 32'(gif.guessValid), 1);
    chk("bounce_data", 32'(gif.guessData), 3);
    tick(5);
    chk("bounce_one_capture", 32'(valid_rises - r0), 1);
    ack_pulse();
    chk("bounce_ack_clears", 32'(gif.guessValid), 0);
    gif.submitRaw = 1'b0;
    tick(8);

    // ack while nothing pending is ignored
    ack_pulse();
    chk("idle_ack_ignored", 32'(gif.guessValid), 0);

    // range / capture table
    for (int i = 0; i < 8; i++) begin
      gif.gameMode = vecs[i].mode;
      gif.guessRaw = vecs[i].guess;
      tick(8);
      gif.submitRaw = 1'b1;
      tick(7);
      chk($sformatf("v%0d_rangeErr", i), 32'(gif.rangeErr), 32'(!vecs[i].accept));
      chk($sformatf("v%0d_valid", i), 32'(gif.guessValid), 32'(vecs[i].accept));
      if (vecs[i].accept) chk($sformatf("v%0d_data", i), 32'(gif.guessData), 32'(vecs[i].guess));
      tick(1);
      chk($sformatf("v%0d_rangeErr_pulse", i), 32'(gif.rangeErr), 0);
      if (vecs[i].accept) begin
        ack_pulse();
        chk($sformatf("v%0d_ack", i), 32'(gif.guessValid), 0);
      end
      chk($sformatf("v%0d_overrun", i), 32'(gif.overrun), 0);
      gif.submitRaw = 1'b0;
      tick(8);
    end

    // overrun: first guess wins, then ack+press back-to-back
    gif.gameMode = 2'b10;
    gif.guessRaw = 4'h3;
    tick(8);
    gif.submitRaw = 1'b1;
    tick(7);
    chk("ovr_first_valid", 32'(gif.guessValid), 1);
    gif.submitRaw = 1'b0;
    gif.guessRaw  = 4'h5;
    tick(8);
    gif.submitRaw = 1'b1;
    tick(7);
    chk("ovr_data_kept", 32'(gif.guessData), 3);
    chk("ovr_flag", 32'(gif.overrun), 1);
    gif.submitRaw = 1'b0;
    tick(8);
    gif.submitRaw = 1'b1;
    tick(6);
    ack_pulse();
    chk("b2b_data", 32'(gif.guessData), 5);
    chk("b2b_valid", 32'(gif.guessValid), 1);
    tick(1);
    chk("b2b_valid_hold", 32'(gif.guessValid), 1);
    chk("b2b_overrun_sticky", 32'(gif.overrun), 1);
    gif.submitRaw = 1'b0;
    tick(8);

    // ready edges
    gif.readyRaw = 1'b1;
    tick(6);
    chk("rise_pulse", 32'(gif.readyRise), 1);
    chk("rise_ready", 32'(gif.ready), 1);
    tick(1);
    chk("rise_pulse_end", 32'(gif.readyRise), 0);
    chk("rise_clears_ovr", 32'(gif.overrun), 0);
    gif.submitRaw = 1'b1;
    tick(7);
    chk("ovr_again", 32'(gif.overrun), 1);
    gif.submitRaw = 1'b0;
    tick(8);
    gif.readyRaw = 1'b0;
    tick(6);
    chk("fall_pulse", 32'(gif.readyFall), 1);
    tick(1);
    chk("fall_pulse_end", 32'(gif.readyFall), 0);
    chk("fall_clears_valid", 32'(gif.guessValid), 0);
    chk("fall_keeps_ovr", 32'(gif.overrun), 1);
    gif.readyRaw = 1'b1;
    tick(8);
    // press and readyFall together: fall wins, nothing captured
    gif.submitRaw = 1'b1;
    gif.readyRaw  = 1'b0;
    tick(6);
    chk("fall_press_fall", 32'(gif.readyFall), 1);
    tick(1);
    chk("fall_press_nocap", 32'(gif.guessValid), 0);
    tick(2);
    chk("fall_press_nocap2", 32'(gif.guessValid), 0);
    gif.submitRaw = 1'b0;
    tick(8);

    // reset mid-settle with a guess pending
    gif.readyRaw = 1'b1;
    gif.guessRaw = 4'h5;
    tick(8);
    gif.submitRaw = 1'b1;
    tick(7);
    chk("pre_rst_valid", 32'(gif.guessValid), 1);
    gif.submitRaw = 1'b0;
    tick(2);
    gif.guessRaw = 4'hA;
    tick(3);
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid",  32'(gif.guessValid), 0);
    chk("arst_data",   32'(gif.guessData), 0);
    chk("arst_ready",  32'(gif.ready), 0);
    chk("arst_guess",  32'(gif.userGuess), 0);
    chk("arst_ovr",    32'(gif.overrun), 0);
    tick(2);
    resetn = 1'b1;
    tick(5);
    chk("post_rst_ready_wait", 32'(gif.ready), 0);
    chk("post_rst_guess_wait", 32'(gif.userGuess), 0);
    tick(1);
    chk("post_rst_ready", 32'(gif.ready), 1);
    chk("post_rst_guess", 32'(gif.userGuess), 32'hA);
    chk("post_rst_rise", 32'(gif.readyRise), 1);
    tick(8);
    chk("post_rst_nocap", 32'(gif.guessValid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
